// File: rtl/ika2151_reg_pkg.sv
// Shared constants for the IKA2151 timer/test register bank: register map,
// timer-control field positions, status byte layout and the bus sample bundle.
`timescale 1ns/1ps
package ika2151_reg_pkg;

  localparam logic [7:0] ADDR_TEST   = 8'h01;
  localparam logic [7:0] ADDR_CLKA1  = 8'h10;
  localparam logic [7:0] ADDR_CLKA2  = 8'h11;
  localparam logic [7:0] ADDR_CLKB   = 8'h12;
  localparam logic [7:0] ADDR_TIMCTL = 8'h14;

  localparam int TC_RUN_A   = 0;
  localparam int TC_RUN_B   = 1;
  localparam int TC_IRQEN_A = 2;
  localparam int TC_IRQEN_B = 3;
  localparam int TC_FRST_A  = 4;
  localparam int TC_FRST_B  = 5;
  localparam int TC_CSM     = 7;

  localparam int STAT_FLAG_A = 0;
  localparam int STAT_FLAG_B = 1;
  localparam int STAT_BUSY   = 7;

  typedef struct packed {
    logic       cs_n;
    logic       wr_n;
    logic       rd_n;
    logic       a0;
    logic [7:0] d;
  } bus_t;

  localparam bus_t BUS_IDLE = '{cs_n: 1'b1, wr_n: 1'b1, rd_n: 1'b1, a0: 1'b0, d: 8'h00};

endpackage

// File: rtl/ika2151_bus_sync.sv
// Two-stage synchroniser for the asynchronous host bus plus WR_n rising-edge
// detection; everything advances only on the phi1 enable.
`timescale 1ns/1ps
module ika2151_bus_sync
  import ika2151_reg_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       i_cs_n,
  input  logic       i_wr_n,
  input  logic       i_rd_n,
  input  logic       i_a0,
  input  logic [7:0] i_d,
  output logic       o_wr_commit,
  output logic       o_a0,
  output logic [7:0] o_d,
  output logic       o_rd_active
);

  bus_t s1_q, s1_d;
  bus_t s2_q, s2_d;
  logic wr_prev_q, wr_prev_d;

  always_comb begin
    s1_d      = s1_q;
    s2_d      = s2_q;
    wr_prev_d = wr_prev_q;
    if (en) begin
      s1_d      = '{cs_n: i_cs_n, wr_n: i_wr_n, rd_n: i_rd_n, a0: i_a0, d: i_d};
      s2_d      = s1_q;
      wr_prev_d = s2_q.wr_n;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q      <= BUS_IDLE;
      s2_q      <= BUS_IDLE;
      wr_prev_q <= 1'b1;
    end else begin
      s1_q      <= s1_d;
      s2_q      <= s2_d;
      wr_prev_q <= wr_prev_d;
    end
  end

  // A0/D come from the same stage as the WR_n edge so they are coherent with it.
  assign o_wr_commit = s2_q.wr_n & ~wr_prev_q & ~s2_q.cs_n;
  assign o_a0        = s2_q.a0;
  assign o_d         = s2_q.d;
  assign o_rd_active = ~s2_q.cs_n & ~s2_q.rd_n;

endmodule

// File: rtl/ika2151_timer_reg.sv
// IKA2151 host interface: decodes address/data write pairs into the timer and
// test registers, tracks the write-busy window and returns the status byte.
`timescale 1ns/1ps
module ika2151_timer_reg
  import ika2151_reg_pkg::*;
#(
  parameter int BUSY_CYCLES = 64
) (
  input  logic       i_EMUCLK,
  input  logic       i_MRST,
  input  logic       i_phi1_NCEN_n,
  input  logic       i_CS_n,
  input  logic       i_WR_n,
  input  logic       i_RD_n,
  input  logic       i_A0,
  input  logic [7:0] i_D,
  input  logic       i_TIMERA_FLAG,
  input  logic       i_TIMERB_FLAG,
  output logic [7:0] o_CLKA1,
  output logic [1:0] o_CLKA2,
  output logic [7:0] o_CLKB,
  output logic       o_TIMERA_RUN,
  output logic       o_TIMERB_RUN,
  output logic       o_TIMERA_IRQ_EN,
  output logic       o_TIMERB_IRQ_EN,
  output logic       o_TIMERA_FRST,
  output logic       o_TIMERB_FRST,
  output logic       o_CSM,
  output logic [7:0] o_TEST,
  output logic [7:0] o_DOUT,
  output logic       o_DOUT_OE
);

  localparam logic [7:0] BUSY_LOAD = 8'(BUSY_CYCLES);

  logic       en;
  logic       wr_commit;
  logic       a0_s;
  logic [7:0] d_s;
  logic       rd_active;
  logic       busy;

  logic [7:0] addr_q, addr_d;
  logic [7:0] test_q, test_d;
  logic [7:0] clka1_q, clka1_d;
  logic [1:0] clka2_q, clka2_d;
  logic [7:0] clkb_q, clkb_d;
  logic       run_a_q, run_a_d, run_b_q, run_b_d;
  logic       irqen_a_q, irqen_a_d, irqen_b_q, irqen_b_d;
  logic       frst_a_q, frst_a_d, frst_b_q, frst_b_d;
  logic       csm_q, csm_d;
  logic [7:0] busy_cnt_q, busy_cnt_d;
  logic [7:0] dout_q, dout_d;
  logic       dout_oe_q, dout_oe_d;

  assign en   = ~i_phi1_NCEN_n;
  assign busy = (busy_cnt_q != 8'd0);

  ika2151_bus_sync u_sync (
    .clk         (i_EMUCLK),
    .rst         (i_MRST),
    .en          (en),
    .i_cs_n      (i_CS_n),
    .i_wr_n      (i_WR_n),
    .i_rd_n      (i_RD_n),
    .i_a0        (i_A0),
    .i_d         (i_D),
    .o_wr_commit (wr_commit),
    .o_a0        (a0_s),
    .o_d         (d_s),
    .o_rd_active (rd_active)
  );

  always_comb begin
    addr_d     = addr_q;
    test_d     = test_q;
    clka1_d    = clka1_q;
    clka2_d    = clka2_q;
    clkb_d     = clkb_q;
    run_a_d    = run_a_q;
    run_b_d    = run_b_q;
    irqen_a_d  = irqen_a_q;
    irqen_b_d  = irqen_b_q;
    frst_a_d   = frst_a_q;
    frst_b_d   = frst_b_q;
    csm_d      = csm_q;
    busy_cnt_d = busy_cnt_q;
    dout_d     = dout_q;
    dout_oe_d  = dout_oe_q;
    if (en) begin
      frst_a_d  = 1'b0;
      frst_b_d  = 1'b0;
      dout_oe_d = rd_active;
      dout_d              = 8'h00;
      dout_d[STAT_BUSY]   = busy;
      dout_d[STAT_FLAG_B] = i_TIMERB_FLAG;
      dout_d[STAT_FLAG_A] = i_TIMERA_FLAG;
      if (busy) begin
        busy_cnt_d = busy_cnt_q - 8'd1;
      end
      if (wr_commit) begin
        if (!a0_s) begin
          addr_d = d_s;
        end else begin
          // Every data write restarts the busy window, even to unmapped addresses.
          busy_cnt_d = BUSY_LOAD;
          case (addr_q)
            ADDR_TEST:  test_d  = d_s;
            ADDR_CLKA1: clka1_d = d_s;
            ADDR_CLKA2: clka2_d = d_s[1:0];
            ADDR_CLKB:  clkb_d  = d_s;
            ADDR_TIMCTL: begin
              csm_d     = d_s[TC_CSM];
              irqen_b_d = d_s[TC_IRQEN_B];
              irqen_a_d = d_s[TC_IRQEN_A];
              run_b_d   = d_s[TC_RUN_B];
              run_a_d   = d_s[TC_RUN_A];
              frst_b_d  = d_s[TC_FRST_B];
              frst_a_d  = d_s[TC_FRST_A];
            end
            default: ;
          endcase
        end
      end
    end
  end

  always_ff @(posedge i_EMUCLK or posedge i_MRST) begin
    if (i_MRST) begin
      addr_q     <= 8'h00;
      test_q     <= 8'h00;
      clka1_q    <= 8'h00;
      clka2_q    <= 2'b00;
      clkb_q     <= 8'h00;
      run_a_q    <= 1'b0;
      run_b_q    <= 1'b0;
      irqen_a_q  <= 1'b0;
      irqen_b_q  <= 1'b0;
      frst_a_q   <= 1'b0;
      frst_b_q   <= 1'b0;
      csm_q      <= 1'b0;
      busy_cnt_q <= 8'h00;
      dout_q     <= 8'h00;
      dout_oe_q  <= 1'b0;
    end else begin
      addr_q     <= addr_d;
      test_q     <= test_d;
      clka1_q    <= clka1_d;
      clka2_q    <= clka2_d;
      clkb_q     <= clkb_d;
      run_a_q    <= run_a_d;
      run_b_q    <= run_b_d;
      irqen_a_q  <= irqen_a_d;
      irqen_b_q  <= irqen_b_d;
      frst_a_q   <= frst_a_d;
      frst_b_q   <= frst_b_d;
      csm_q      <= csm_d;
      busy_cnt_q <= busy_cnt_d;
      dout_q     <= dout_d;
      dout_oe_q  <= dout_oe_d;
    end
  end

  assign o_CLKA1         = clka1_q;
  assign o_CLKA2         = clka2_q;
  assign o_CLKB          = clkb_q;
  assign o_TIMERA_RUN    = run_a_q;
  assign o_TIMERB_RUN    = run_b_q;
  assign o_TIMERA_IRQ_EN = irqen_a_q;
  assign o_TIMERB_IRQ_EN = irqen_b_q;
  assign o_TIMERA_FRST   = frst_a_q;
  assign o_TIMERB_FRST   = frst_b_q;
  assign o_CSM           = csm_q;
  assign o_TEST          = test_q;
  assign o_DOUT          = dout_q;
  assign o_DOUT_OE       = dout_oe_q;

endmodule

// File: tb/tb_ika2151_timer_reg.sv
// Bench for ika2151_timer_reg: directed host-bus scenarios plus random writes,
// compared every clock against a delay-line reference model of the host interface.
`timescale 1ns/1ps
module tb_ika2151_timer_reg;

  localparam int BUSY = 64;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ncen = 1'b1;
  logic       cs_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1, a0 = 1'b0;
  logic [7:0] d = 8'h00;
  logic       fa = 1'b0, fb = 1'b0;

  logic [7:0] clka1, clkb, test, dout;
  logic [1:0] clka2;
  logic       runa, runb, irqa, irqb, frsta, frstb, csm, oe;

  int cmps = 0;
  int errs = 0;

  ika2151_timer_reg #(.BUSY_CYCLES(BUSY)) dut (
    .i_EMUCLK(clk), .i_MRST(rst), .i_phi1_NCEN_n(ncen),
    .i_CS_n(cs_n), .i_WR_n(wr_n), .i_RD_n(rd_n), .i_A0(a0), .i_D(d),
    .i_TIMERA_FLAG(fa), .i_TIMERB_FLAG(fb),
    .o_CLKA1(clka1), .o_CLKA2(clka2), .o_CLKB(clkb),
    .o_TIMERA_RUN(runa), .o_TIMERB_RUN(runb),
    .o_TIMERA_IRQ_EN(irqa), .o_TIMERB_IRQ_EN(irqb),
    .o_TIMERA_FRST(frsta), .o_TIMERB_FRST(frstb),
    .o_CSM(csm), .o_TEST(test), .o_DOUT(dout), .o_DOUT_OE(oe)
  );

  always #5 clk = ~clk;

  // Reference model: bus samples taken at each enable, aged through a history.
  typedef struct packed {logic cs, wr, rd, a0; logic [7:0] d;} smp_t;
  localparam smp_t IDLE = '{cs: 1'b1, wr: 1'b1, rd: 1'b1, a0: 1'b0, d: 8'h00};
  smp_t h1, h2, h3;
  logic [7:0] m_addr, m_test, m_clka1, m_clkb, m_dout;
  logic [1:0] m_clka2;
  logic m_runa, m_runb, m_irqa, m_irqb, m_frsta, m_frstb, m_csm, m_oe;
  int m_busy, n_en = 0, last_commit = 0;
  int frsta_seen, frstb_seen, busy_seen;

  wire [41:0] outs = {clka1, clka2, clkb, runa, runb, irqa, irqb, frsta, frstb, csm, test, dout, oe};
  wire [41:0] expv = {m_clka1, m_clka2, m_clkb, m_runa, m_runb, m_irqa, m_irqb,
                      m_frsta, m_frstb, m_csm, m_test, m_dout, m_oe};

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    cmps++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    h1 = IDLE; h2 = IDLE; h3 = IDLE;
    m_addr = 0; m_test = 0; m_clka1 = 0; m_clka2 = 0; m_clkb = 0; m_dout = 0;
    m_runa = 0; m_runb = 0; m_irqa = 0; m_irqb = 0; m_frsta = 0; m_frstb = 0;
    m_csm = 0; m_oe = 0; m_busy = 0;
  endtask

  // A write lands two enables after the first high WR_n sample is seen.
  task automatic model_step();
    smp_t cur;
    logic commit;
    cur = '{cs: cs_n, wr: wr_n, rd: rd_n, a0: a0, d: d};
    n_en++;
    commit = h2.wr && !h3.wr && !h2.cs;
    m_dout = {(m_busy != 0), 5'b0, fb, fa};
    m_oe = !h2.cs && !h2.rd;
    m_frsta = 0; m_frstb = 0;
    if (m_busy > 0) m_busy--;
    if (commit) begin
      if (!h2.a0) m_addr = h2.d;
      else begin
        m_busy = BUSY;
        last_commit = n_en;
        if (m_addr == 8'h01) m_test = h2.d;
        else if (m_addr == 8'h10) m_clka1 = h2.d;
        else if (m_addr == 8'h11) m_clka2 = h2.d[1:0];
        else if (m_addr == 8'h12) m_clkb = h2.d;
        else if (m_addr == 8'h14) begin
          m_csm = h2.d[7]; m_frstb = h2.d[5]; m_frsta = h2.d[4];
          m_irqb = h2.d[3]; m_irqa = h2.d[2]; m_runb = h2.d[1]; m_runa = h2.d[0];
        end
      end
    end
    h3 = h2; h2 = h1; h1 = cur;
  endtask

  task automatic tick();
    int idle;
    idle = $urandom_range(0, 2);
    for (int i = 0; i < idle; i++) begin
      @(negedge clk) ncen = 1'b1;
      @(posedge clk);
      #1 check("hold", {22'b0, outs}, {22'b0, expv});
    end
    @(negedge clk) ncen = 1'b0;
    @(posedge clk);
    model_step();
    #1 check("enable", {22'b0, outs}, {22'b0, expv});
    if (frsta) frsta_seen++;
    if (frstb) frstb_seen++;
    if (dout[7]) busy_seen++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic host_write(input logic a, input logic [7:0] v, input logic c);
    cs_n = c; a0 = a; d = v;
    tick();
    wr_n = 1'b0;
    ticks(2);
    wr_n = 1'b1;
    ticks(4);
    cs_n = 1'b1;
    tick();
  endtask

  task automatic host_read(input logic [7:0] exp);
    cs_n = 1'b0; rd_n = 1'b0;
    ticks(4);
    check("read_oe", {63'b0, oe}, 64'd1);
    check("read_dout", {56'b0, dout}, {56'b0, exp});
    rd_n = 1'b1; cs_n = 1'b1;
    ticks(3);
  endtask

  initial begin
    logic [7:0] v;
    int c1;
    model_reset();
    #1 check("reset_outs", {22'b0, outs}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    ticks(4);
    host_read(8'h00);

    // CLKA1 with exact commit latency and busy window
    host_write(1'b0, 8'h10, 1'b0);
    busy_seen = 0;
    cs_n = 1'b0; a0 = 1'b1; d = 8'hA5;
    tick();
    wr_n = 1'b0;
    ticks(2);
    wr_n = 1'b1;
    ticks(2);
    check("clka1_before", {56'b0, clka1}, 64'h00);
    tick();
    check("clka1_after", {56'b0, clka1}, 64'hA5);
    ticks(2);
    cs_n = 1'b1;
    host_read(8'h80);
    ticks(80);
    check("busy_len", busy_seen, BUSY);
    host_read(8'h00);

    // Timer control: FRST pulses, then IRQ_EN clear with RUN kept
    host_write(1'b0, 8'h14, 1'b0);
    frsta_seen = 0; frstb_seen = 0;
    host_write(1'b1, 8'h3F, 1'b0);
    check("run_ab", {62'b0, runb, runa}, 64'd3);
    check("irq_ab", {62'b0, irqb, irqa}, 64'd3);
    check("frsta_width", frsta_seen, 1);
    check("frstb_width", frstb_seen, 1);
    host_write(1'b1, 8'h03, 1'b0);
    check("irq_cleared", {62'b0, irqb, irqa}, 64'd0);
    check("run_held", {62'b0, runb, runa}, 64'd3);
    ticks(70);

    // Unmapped address with busy extension
    host_write(1'b0, 8'h13, 1'b0);
    busy_seen = 0;
    host_write(1'b1, 8'hFF, 1'b0);
    c1 = last_commit;
    while (n_en < c1 + 30) tick();
    host_write(1'b1, 8'hFF, 1'b0);
    ticks(90);
    check("busy_extend", busy_seen, last_commit - c1 + BUSY);
    check("unmapped_clka1", {56'b0, clka1}, 64'hA5);
    check("unmapped_ctl", {57'b0, csm, irqb, irqa, runb, runa, clka2}, 64'h0C);

    // Status flags, idle and busy
    fa = 1'b1; fb = 1'b1;
    host_read(8'h03);
    host_write(1'b1, 8'h00, 1'b0);
    host_read(8'h83);
    ticks(70);
    fa = 1'b0; fb = 1'b0;

    // Write strobe with chip select high is ignored
    host_write(1'b0, 8'h12, 1'b0);
    v = 8'($urandom_range(0, 127)) << 1;
    host_write(1'b1, v, 1'b0);
    ticks(70);
    busy_seen = 0;
    host_write(1'b1, 8'h55, 1'b1);
    ticks(10);
    check("cs_high_clkb", {56'b0, clkb}, {56'b0, v | 8'h00});
    check("cs_high_busy", busy_seen, 0);

    // Random writes, some with overlapping reads
    for (int k = 0; k < 40; k++) begin
      int sel;
      sel = $urandom_range(0, 6);
      fa = 1'($urandom); fb = 1'($urandom);
      rd_n = 1'($urandom);
      case (sel)
        0: v = 8'h01; 1: v = 8'h10; 2: v = 8'h11; 3: v = 8'h12;
        4: v = 8'h14; 5: v = 8'h13; default: v = 8'($urandom);
      endcase
      host_write(1'b0, v, ($urandom_range(0, 7) == 0));
      host_write(1'b1, 8'($urandom), ($urandom_range(0, 7) == 0));
      rd_n = 1'b1;
      ticks($urandom_range(0, 8));
    end
    fa = 1'b0; fb = 1'b0;
    ticks(70);

    // Asynchronous reset in the middle of a write
    cs_n = 1'b0; a0 = 1'b1; d = 8'($urandom);
    wr_n = 1'b0;
    ticks(2);
    @(negedge clk);
    #2 rst = 1'b1;
    wr_n = 1'b1; cs_n = 1'b1;
    #1 model_reset();
    check("async_reset", {22'b0, outs}, 64'd0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    ticks(4);
    host_read(8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmps, errs);
    $finish;
  end

endmodule
